// File: rtl/nes_poll_sequencer.sv
// NES/SNES controller poll sequencer: latch, shift pulses, parallel capture.
// Define NES_MATCH_EN to update buttons only on two identical frames.
module nes_poll_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int NUM_BITS    = 8,
  parameter int TICK_DIV    = 1,
  parameter int LATCH_TICKS = 2,
  parameter int PULSE_TICKS = 1,
  parameter int POLL_TICKS  = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          nes_data,
  output logic                       nes_latch,
  output logic                       nes_pulse,
  output logic [NUM_CH*NUM_BITS-1:0] buttons,
  output logic                       valid,
  output logic                       busy
);

  localparam int W    = NUM_CH * NUM_BITS;
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SLOT = 2 * PULSE_TICKS;
  localparam int TMAX = (LATCH_TICKS > SLOT) ? LATCH_TICKS : SLOT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(NUM_BITS);
  localparam int CW   = $clog2(POLL_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PW-1:0]  r_pre;
  logic [TW-1:0]  r_tcnt;
  logic [TW-1:0]  w_tcnt_nxt;
  logic [BW-1:0]  r_bit;
  logic [BW-1:0]  w_bit_nxt;
  logic [CW-1:0]  r_poll;
  logic [W-1:0]   r_shift;
  logic [W-1:0]   w_shift_nxt;
  logic [W-1:0]   r_buttons;
  logic           w_tick;
  logic           w_due;
  logic           w_start;
  logic           w_sample;
  logic [BW-1:0]  w_sidx;
  logic           w_load;

  assign w_tick  = (r_pre == PW'(TICK_DIV - 1));
  assign w_due   = (r_poll >= CW'(POLL_TICKS - 1));
  assign w_start = (r_state == S_IDLE) && w_tick && enable && w_due;
  assign w_load  = (r_state == S_SHIFT) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Reset value is the saturated count so the first frame is due at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_poll <= CW'(POLL_TICKS);
    end else if (w_start) begin
      r_poll <= '0;
    end else if (w_tick && (r_poll != CW'(POLL_TICKS))) begin
      r_poll <= r_poll + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    w_sidx      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LATCH;
          w_tcnt_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_LATCH: begin
        if (w_tick) begin
          if (r_tcnt == TW'(LATCH_TICKS - 1)) begin
            w_sample    = 1'b1;
            w_sidx      = '0;
            w_state_nxt = S_SHIFT;
            w_tcnt_nxt  = '0;
            w_bit_nxt   = BW'(1);
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          if (r_tcnt == TW'(SLOT - 1)) begin
            w_sample   = 1'b1;
            w_sidx     = r_bit;
            w_tcnt_nxt = '0;
            if (r_bit == BW'(NUM_BITS - 1)) begin
              w_state_nxt = S_DONE;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_tcnt_nxt  = '0;
        w_bit_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Lines are active-low; store 1 = pressed.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_sample) begin
      for (int c = 0; c < NUM_CH; c++) begin
        w_shift_nxt[c*NUM_BITS + int'(w_sidx)] = ~nes_data[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_nxt;
    end
  end

`ifdef NES_MATCH_EN
  logic [W-1:0] r_prev;
  logic [W-1:0] w_btn_nxt;

  always_comb begin
    w_btn_nxt = r_buttons;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_shift_nxt[c*NUM_BITS +: NUM_BITS] ==
          r_prev[c*NUM_BITS +: NUM_BITS]) begin
        w_btn_nxt[c*NUM_BITS +: NUM_BITS] =
          w_shift_nxt[c*NUM_BITS +: NUM_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buttons <= '0;
      r_prev    <= '0;
    end else if (w_load) begin
      r_buttons <= w_btn_nxt;
      r_prev    <= w_shift_nxt;
    end
  end
`else
  // Loaded on entry to DONE so buttons and valid appear together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buttons <= '0;
    end else if (w_load) begin
      r_buttons <= w_shift_nxt;
    end
  end
`endif

  assign nes_latch = (r_state == S_LATCH);
  assign nes_pulse = (r_state == S_SHIFT) && (r_tcnt < TW'(PULSE_TICKS));
  assign valid     = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign buttons   = r_buttons;

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Scoreboard bench for nes_poll_sequencer: frame timing, capture, reset, enable.
// Three instances: main (POLL 40), fast (POLL 10), big (SNES-style timing).
module tb_nes_poll_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [1:0]  dat;
  logic        lat, pul, vld, bsy;
  logic [15:0] btn;

  logic [1:0]  f_dat;
  logic        f_lat, f_pul, f_vld, f_bsy;
  logic [15:0] f_btn;

  logic        b_rst, b_en;
  logic [0:0]  b_dat;
  logic        b_lat, b_pul, b_vld, b_bsy;
  logic [15:0] b_btn;

  assign f_dat = 2'b10;

  nes_poll_sequencer #(.POLL_TICKS(40)) u_dut (
    .clk(clk), .reset(rst_n), .enable(en), .nes_data(dat),
    .nes_latch(lat), .nes_pulse(pul), .buttons(btn),
    .valid(vld), .busy(bsy)
  );

  nes_poll_sequencer #(.POLL_TICKS(10)) u_fast (
    .clk(clk), .reset(rst_n), .enable(en), .nes_data(f_dat),
    .nes_latch(f_lat), .nes_pulse(f_pul), .buttons(f_btn),
    .valid(f_vld), .busy(f_bsy)
  );

  nes_poll_sequencer #(
    .NUM_CH(1), .NUM_BITS(16), .TICK_DIV(4), .LATCH_TICKS(3),
    .PULSE_TICKS(2), .POLL_TICKS(200)
  ) u_big (
    .clk(clk), .reset(b_rst), .enable(b_en), .nes_data(b_dat),
    .nes_latch(b_lat), .nes_pulse(b_pul), .buttons(b_btn),
    .valid(b_vld), .busy(b_bsy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller models: load on latch, shift on pulse rise.
  logic [7:0]  raw0, raw1;
  logic [15:0] raw_b;
  int idx = 0, bidx = 0;
  logic pprev = 1'b0, bpprev = 1'b0;

  always @(negedge clk) begin
    if (lat) idx = 0;
    else if (pul && !pprev && idx < 7) idx = idx + 1;
    pprev = pul;
    dat = {raw1[idx], raw0[idx]};
    if (b_lat) bidx = 0;
    else if (b_pul && !bpprev && bidx < 15) bidx = bidx + 1;
    bpprev = b_pul;
    b_dat = raw_b[bidx];
  end

  logic [15:0] q[$];
  logic [15:0] q_b[$];

  always @(negedge clk) begin
    if (vld) begin
      chk("valid_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) chk("buttons", 32'(btn), 32'(q.pop_front()));
    end
    if (b_vld) begin
      chk("b_valid_expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) chk("b_buttons", 32'(b_btn), 32'(q_b.pop_front()));
    end
  end

  int b_lat_cnt = 0, b_rise = 0, b_hi_run = 0, b_lo_run = 0;
  int b_hi_bad = 0, b_lo_bad = 0;
  logic b_seen_fall = 1'b0, b_mprev = 1'b0;

  always @(negedge clk) begin
    if (b_lat) b_lat_cnt++;
    if (b_pul) begin
      if (!b_mprev) begin
        b_rise++;
        if (b_seen_fall && b_lo_run != 8) b_lo_bad++;
        b_hi_run = 0;
      end
      b_hi_run++;
    end else begin
      if (b_mprev) begin
        if (b_hi_run != 8) b_hi_bad++;
        b_seen_fall = 1'b1;
        b_lo_run = 0;
      end
      b_lo_run++;
    end
    b_mprev = b_pul;
  end

  logic m_lat[0:63], m_pul[0:63], m_val[0:63];
  logic a_lat[0:63], a_val[0:63];
  logic [15:0] a_btn[0:63];

  task automatic rec(input int c);
    m_lat[c] = lat; m_pul[c] = pul; m_val[c] = vld;
    a_lat[c] = f_lat; a_val[c] = f_vld; a_btn[c] = f_btn;
  endtask

  logic [7:0]  pat6[3];
  logic [15:0] exp6[3];

  initial begin
    int k, pc, vc;
    rst_n = 1'b0; en = 1'b0; raw0 = 8'hFF; raw1 = 8'hFF;
    b_rst = 1'b0; b_en = 1'b0; raw_b = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(lat), 0);
    chk("rst_pulse", 32'(pul), 0);
    chk("rst_buttons", 32'(btn), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_busy", 32'(bsy), 0);

    // Frame timing and capture; a second frame follows 40 ticks later.
    raw0 = 8'h5A; raw1 = 8'hFF;
    q.push_back(16'h00A5);
    q.push_back(16'h00A5);
    en = 1'b1; rst_n = 1'b1;
    rec(0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      rec(c);
    end
    chk("t1_lat_c0", 32'(m_lat[0]), 0);
    chk("t1_lat_c1", 32'(m_lat[1]), 1);
    chk("t1_lat_c2", 32'(m_lat[2]), 1);
    chk("t1_lat_c3", 32'(m_lat[3]), 0);
    pc = 0;
    for (int c = 1; c <= 17; c++) pc += int'(m_pul[c]);
    chk("t1_pulse_cnt", 32'(pc), 7);
    chk("t1_pul_c3", 32'(m_pul[3]), 1);
    chk("t1_pul_c15", 32'(m_pul[15]), 1);
    chk("t1_pul_c16", 32'(m_pul[16]), 0);
    chk("t1_valid_c17", 32'(m_val[17]), 1);
    vc = 0;
    for (int c = 1; c <= 40; c++) vc += int'(m_val[c]);
    chk("t1_valid_cnt", 32'(vc), 1);
    chk("t1_lat_c40", 32'(m_lat[40]), 0);
    chk("t1_lat_c41", 32'(m_lat[41]), 1);
    chk("t1_sb_drained", 32'(q.size()), 0);

    // Poll period shorter than the frame.
    chk("t2_lat_c18", 32'(a_lat[18]), 0);
    chk("t2_lat_c19", 32'(a_lat[19]), 1);
    chk("t2_valid_c17", 32'(a_val[17]), 1);
    chk("t2_valid_c35", 32'(a_val[35]), 1);
    vc = 0;
    for (int c = 1; c <= 60; c++) vc += int'(a_val[c]);
    chk("t2_valid_cnt", 32'(vc), 3);
    chk("t2_buttons", 32'(a_btn[17]), 32'h00FF);

    // Mid-frame reset during bit 4.
    k = 0;
    while (!lat && k < 100) begin @(negedge clk); k++; end
    chk("t4_latch_seen", 32'(lat), 1);
    repeat (8) @(negedge clk);
    chk("t4_pulse_bit4", 32'(pul), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_pulse", 32'(pul), 0);
    chk("t4_busy", 32'(bsy), 0);
    chk("t4_buttons", 32'(btn), 0);
    chk("t4_valid", 32'(vld), 0);
    raw0 = 8'h3C;
    q.push_back(16'h00C3);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!vld && k < 40) begin @(negedge clk); k++; end
    chk("t4_valid_seen", 32'(vld), 1);

    // Enable dropped during LATCH.
    k = 0;
    while (!lat && k < 60) begin @(negedge clk); k++; end
    chk("t5_latch_seen", 32'(lat), 1);
    q.push_back(16'h00C3);
    en = 1'b0;
    k = 0;
    while (!vld && k < 40) begin @(negedge clk); k++; end
    chk("t5_valid_seen", 32'(vld), 1);
    pc = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      pc += int'(lat);
    end
    chk("t5_no_latch", 32'(pc), 0);

    // Frame match sequence.
    pat6[0] = 8'h11; pat6[1] = 8'h22; pat6[2] = 8'h22;
`ifdef NES_MATCH_EN
    exp6[0] = 16'h0000; exp6[1] = 16'h0000; exp6[2] = 16'h0022;
`else
    exp6[0] = 16'h0011; exp6[1] = 16'h0022; exp6[2] = 16'h0022;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    raw1 = 8'hFF;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      raw0 = ~pat6[i];
      q.push_back(exp6[i]);
      rst_n = 1'b1;
      k = 0;
      while (!vld && k < 60) begin @(negedge clk); k++; end
      chk("t6_valid_seen", 32'(vld), 1);
      @(negedge clk);
    end
    en = 1'b0;
    chk("t6_sb_drained", 32'(q.size()), 0);

    // Divided tick, 16-bit frame.
    raw_b = 16'hA53C;
    q_b.push_back(16'h5AC3);
    b_en = 1'b1; b_rst = 1'b1;
    k = 0;
    while (!b_vld && k < 400) begin @(negedge clk); k++; end
    chk("t3_valid_seen", 32'(b_vld), 1);
    b_en = 1'b0;
    chk("t3_latch_clks", 32'(b_lat_cnt), 12);
    chk("t3_pulse_cnt", 32'(b_rise), 15);
    chk("t3_high_runs", 32'(b_hi_bad), 0);
    chk("t3_low_runs", 32'(b_lo_bad), 0);
    @(negedge clk);
    chk("t3_sb_drained", 32'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
